// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one single-ported memory between the IF and DM
// pipeline stages. DM has fixed priority. A starvation limiter forces IF
// through after STARVE_LIM consecutive denied cycles. Read data is routed
// back to its owner LAT cycles after the grant, and the per-stage stalls are
// produced here.
// Optional feature: define ARB_PERF_CNT_EN to enable the conflict_cnt
// performance counter. When it is undefined, conflict_cnt is tied to zero.
module pipe_mem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int LAT        = 1,
  parameter int STARVE_LIM = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic [DW-1:0] if_rdata,
  output logic          if_rvalid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic [15:0]   conflict_cnt
);

  localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  logic [SW-1:0]  starve_cnt;
  logic           force_if;
  logic [LAT-1:0] tag_valid;
  logic [LAT-1:0] tag_owner;
  logic [DW-1:0]  if_rdata_q;
  logic [DW-1:0]  dm_rdata_q;
  logic           ret_if;
  logic           ret_dm;

  // IF wins outright once it has been denied STARVE_LIM cycles in a row
  always_comb begin
    force_if = (STARVE_LIM != 0) && (starve_cnt == SW'(STARVE_LIM));
  end

  // Grant selection: DM priority unless IF is being forced; nothing granted in reset
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!reset) begin
      if (force_if && if_req) begin
        if_gnt = 1'b1;
      end else begin
        dm_gnt = dm_req;
        if_gnt = if_req & ~dm_req;
      end
    end
  end

  // Stalls seen by the hazard logic
  always_comb begin
    stall_if  = ~reset & if_req & ~if_gnt;
    stall_mem = ~reset & dm_req & ~dm_gnt;
  end

  // Memory port driven from the granted requester, zero when idle
  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  // Count consecutive denied IF cycles, saturating at the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (if_gnt || !if_req) begin
      starve_cnt <= '0;
    end else if (STARVE_LIM != 0 && starve_cnt != SW'(STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Read-return tag pipeline; writes insert an empty slot
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid <= '0;
      tag_owner <= '0;
    end else begin
      tag_valid[0] <= if_gnt | (dm_gnt & ~dm_we);
      tag_owner[0] <= dm_gnt ? OWN_DM : OWN_IF;
      for (int i = 1; i < LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_owner[i] <= tag_owner[i-1];
      end
    end
  end

  // Returning read at the last stage; suppressed while reset is high so
  // reads in flight at reset never report
  always_comb begin
    ret_if    = ~reset & tag_valid[LAT-1] & (tag_owner[LAT-1] == OWN_IF);
    ret_dm    = ~reset & tag_valid[LAT-1] & (tag_owner[LAT-1] == OWN_DM);
    if_rvalid = ret_if;
    dm_rvalid = ret_dm;
    if_rdata  = ret_if ? mem_rdata : if_rdata_q;
    dm_rdata  = ret_dm ? mem_rdata : dm_rdata_q;
  end

  // Each owner keeps its last returned data between returns
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (ret_if) if_rdata_q <= mem_rdata;
      if (ret_dm) dm_rdata_q <= mem_rdata;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] conflict_q;

  // Saturating count of cycles where both stages want the memory
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_q <= '0;
    end else if (if_req && dm_req && conflict_q != 16'hFFFF) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule
